// File: rtl/mem_io_responder_if.sv
// Datapath-side MAR/MDR request bus between the LC-3 datapath (master) and
// the memory/I-O responder (slave).
interface mem_io_responder_if;
    logic        MEM_EN;
    logic        WE;
    logic [15:0] MAR;
    logic [15:0] MDR_out;
    logic [15:0] MDR_in;
    logic        R;

    modport master (output MEM_EN, WE, MAR, MDR_out, input MDR_in, R);
    modport slave  (input MEM_EN, WE, MAR, MDR_out, output MDR_in, R);
endinterface

// File: rtl/mem_io_responder.sv
// LC-3 memory responder: SRAM accesses through a wait-state FSM plus the I/O register at IO_ADDR.
// Optional read/write access counters are enabled by defining ACCESS_STATS_EN.
//
// state   | meaning
// IDLE    | waiting for MEM_EN; request is latched on acceptance
// ACCESS  | SRAM strobes active, wait counter running
// IO      | single-cycle switch read / hex write
// DONE    | R pulse, read data valid on MDR_in
// RELEASE | waiting for MEM_EN to drop so one request gives one access
module mem_io_responder #(
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic                Clk,
    input  logic                Reset,
    mem_io_responder_if.slave   bus,
    input  logic [15:0]         Switches,
    output logic [15:0]         HEX_out,
    output logic [19:0]         SRAM_ADDR,
    output logic [15:0]         SRAM_DQ_wr,
    input  logic [15:0]         SRAM_DQ_rd,
    output logic                SRAM_CE_N,
    output logic                SRAM_OE_N,
    output logic                SRAM_WE_N
`ifdef ACCESS_STATS_EN
    ,
    output logic [15:0]         RD_COUNT,
    output logic [15:0]         WR_COUNT
`endif
);

    typedef enum logic [2:0] {IDLE, ACCESS, IO, DONE, RELEASE} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  wait_cnt;
    logic [15:0] mar_q;
    logic [15:0] dat_q;
    logic [15:0] mdr_q;
    logic        we_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.MEM_EN) state_nxt = (bus.MAR == IO_ADDR) ? IO : ACCESS;
            ACCESS:  if (wait_cnt == 4'd0) state_nxt = DONE;
            IO:      state_nxt = DONE;
            DONE:    state_nxt = bus.MEM_EN ? RELEASE : IDLE;
            RELEASE: if (!bus.MEM_EN) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        SRAM_CE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        bus.R     = 1'b0;
        if (state == ACCESS) begin
            SRAM_CE_N = 1'b0;
            SRAM_OE_N = we_q;
            SRAM_WE_N = !we_q;
        end
        if (state == DONE) bus.R = 1'b1;
    end

    // Request fields are latched at acceptance so bus changes mid-access are ignored.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mar_q    <= '0;
            dat_q    <= '0;
            we_q     <= 1'b0;
            wait_cnt <= '0;
            mdr_q    <= '0;
            HEX_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.MEM_EN) begin
                        mar_q    <= bus.MAR;
                        dat_q    <= bus.MDR_out;
                        we_q     <= bus.WE;
                        wait_cnt <= WAIT_INIT;
                    end
                end
                ACCESS: begin
                    if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                    else if (!we_q)       mdr_q    <= SRAM_DQ_rd;
                end
                IO: begin
                    if (we_q) HEX_out <= dat_q;
                    else      mdr_q   <= Switches;
                end
                default: ;
            endcase
        end
    end

    assign bus.MDR_in = mdr_q;
    assign SRAM_ADDR  = {4'b0000, mar_q};
    assign SRAM_DQ_wr = dat_q;

`ifdef ACCESS_STATS_EN
    // Only accesses that reach DONE are counted; a reset abort never gets there.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            RD_COUNT <= '0;
            WR_COUNT <= '0;
        end else if (state == DONE) begin
            if (we_q) WR_COUNT <= WR_COUNT + 16'd1;
            else      RD_COUNT <= RD_COUNT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: requests push expected MDR_in/latency,
// a monitor pops and checks on every R pulse.
module tb_mem_io_responder;
    localparam int WS = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] Switches;
    logic [15:0] HEX_out;
    logic [19:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_wr;
    logic [15:0] SRAM_DQ_rd;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;
`ifdef ACCESS_STATS_EN
    logic [15:0] RD_COUNT, WR_COUNT;
`endif

    mem_io_responder_if bus();

    mem_io_responder #(.WAIT_STATES(WS), .IO_ADDR(16'hFFFF)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .bus        (bus),
        .Switches   (Switches),
        .HEX_out    (HEX_out),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_DQ_wr (SRAM_DQ_wr),
        .SRAM_DQ_rd (SRAM_DQ_rd),
        .SRAM_CE_N  (SRAM_CE_N),
        .SRAM_OE_N  (SRAM_OE_N),
        .SRAM_WE_N  (SRAM_WE_N)
`ifdef ACCESS_STATS_EN
        ,
        .RD_COUNT   (RD_COUNT),
        .WR_COUNT   (WR_COUNT)
`endif
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] mdr;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_mdr;
    logic [15:0] exp_hex;
    int          exp_rd;
    int          exp_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    initial begin
        forever begin
            @(negedge Clk);
            if (bus.R === 1'b1) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_r: R=1 with no pending request, expected 0 (cycle %0d)", cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("mdr_in", bus.MDR_in, mon_e.mdr);
                    chk("r_latency_cycle", cyc, mon_e.due);
                end
            end
        end
    end

    // hold: extra cycles MEM_EN stays high after R; early: drop MEM_EN right after acceptance
    task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] data,
                          input int hold, input bit early);
        int   ce_n = 0, oe_n = 0, we_n = 0, dq_bad = 0, addr_bad = 0, wait_n = 0;
        int   extra_r = 0, extra_ce = 0;
        bit   is_io;
        exp_t e;
        is_io = (addr == 16'hFFFF);
        @(negedge Clk);
        bus.MEM_EN  = 1'b1;
        bus.WE      = we;
        bus.MAR     = addr;
        bus.MDR_out = data;
        if (!we) exp_mdr = is_io ? Switches : SRAM_DQ_rd;
        if (we && is_io) exp_hex = data;
        if (we) exp_wr++; else exp_rd++;
        e.mdr = exp_mdr;
        e.due = cyc + (is_io ? 2 : WS + 1);
        sbq.push_back(e);
        @(negedge Clk);
        bus.MAR     = ~addr;
        bus.MDR_out = ~data;
        bus.WE      = ~we;
        if (early) bus.MEM_EN = 1'b0;
        while (1) begin
            if (!SRAM_CE_N) ce_n++;
            if (!SRAM_OE_N) oe_n++;
            if (!SRAM_WE_N) begin
                we_n++;
                if (SRAM_DQ_wr !== data) dq_bad++;
            end
            if (!SRAM_CE_N && SRAM_ADDR !== {4'h0, addr}) addr_bad++;
            if (bus.R === 1'b1 || wait_n == 50) break;
            wait_n++;
            @(negedge Clk);
        end
        if (bus.R !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL r_timeout: R not seen within 50 cycles for addr %0h, expected 1", addr);
        end
        chk("ce_low_cycles", ce_n, is_io ? 0 : WS);
        chk("oe_low_cycles", oe_n, (!we && !is_io) ? WS : 0);
        chk("we_low_cycles", we_n, (we && !is_io) ? WS : 0);
        chk("sram_dq_wr_bad", dq_bad, 0);
        chk("sram_addr_bad", addr_bad, 0);
        chk("hex_out", HEX_out, exp_hex);
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge Clk);
                if (bus.R === 1'b1) extra_r++;
                if (!SRAM_CE_N) extra_ce++;
            end
            chk("release_extra_r", extra_r, 0);
            chk("release_extra_ce", extra_ce, 0);
        end
        bus.MEM_EN = 1'b0;
    endtask

    task automatic chk_stats;
`ifdef ACCESS_STATS_EN
        @(negedge Clk);
        chk("rd_count", RD_COUNT, exp_rd);
        chk("wr_count", WR_COUNT, exp_wr);
`endif
    endtask

    initial begin
        Reset       = 1'b1;
        bus.MEM_EN  = 1'b0;
        bus.WE      = 1'b0;
        bus.MAR     = '0;
        bus.MDR_out = '0;
        Switches    = '0;
        SRAM_DQ_rd  = '0;
        exp_mdr     = '0;
        exp_hex     = '0;
        exp_rd      = 0;
        exp_wr      = 0;
        repeat (2) @(negedge Clk);
        chk("rst_r", bus.R, 1'b0);
        chk("rst_mdr_in", bus.MDR_in, 16'h0);
        chk("rst_hex", HEX_out, 16'h0);
        chk("rst_sram_addr", SRAM_ADDR, 20'h0);
        chk("rst_dq_wr", SRAM_DQ_wr, 16'h0);
        chk("rst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 3'b111);
        Reset = 1'b0;

        SRAM_DQ_rd = 16'hBEEF;
        do_req(1'b0, 16'h0010, 16'h0000, 0, 1'b0);
        SRAM_DQ_rd = 16'h5555;
        do_req(1'b1, 16'h0020, 16'h1234, 0, 1'b0);
        Switches = 16'h00A5;
        do_req(1'b0, 16'hFFFF, 16'h0000, 0, 1'b0);
        do_req(1'b1, 16'hFFFF, 16'h0C3D, 0, 1'b0);
        SRAM_DQ_rd = 16'hCAFE;
        do_req(1'b0, 16'hFFFE, 16'h0000, 6, 1'b0);
        Switches = 16'h3C3C;
        do_req(1'b0, 16'hFFFF, 16'h0000, 0, 1'b1);
        SRAM_DQ_rd = 16'h0F0F;
        do_req(1'b1, 16'h0100, 16'hA5A5, 0, 1'b0);
        chk_stats();

        // Abort a write in ACCESS with reset
        @(negedge Clk);
        bus.MEM_EN  = 1'b1;
        bus.WE      = 1'b1;
        bus.MAR     = 16'h0005;
        bus.MDR_out = 16'h7777;
        @(negedge Clk);
        chk("abort_ce_active", SRAM_CE_N, 1'b0);
        chk("abort_we_active", SRAM_WE_N, 1'b0);
        Reset = 1'b1;
        #1;
        chk("abort_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 3'b111);
        chk("abort_hex", HEX_out, 16'h0);
        chk("abort_mdr_in", bus.MDR_in, 16'h0);
        chk("abort_r", bus.R, 1'b0);
        exp_mdr = '0;
        exp_hex = '0;
        exp_rd  = 0;
        exp_wr  = 0;
        @(negedge Clk);
        bus.MEM_EN = 1'b0;
        Reset      = 1'b0;
        repeat (2) @(negedge Clk);

        SRAM_DQ_rd = 16'h1357;
        do_req(1'b0, 16'h0005, 16'h0000, 0, 1'b0);
        chk_stats();

        repeat (3) @(negedge Clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
Memory-side responder for the LC-3 datapath's MAR/MDR bus. It accepts a read or write request addressed by MAR and serves it from external SRAM through a wait-state FSM, or from the memory-mapped I/O register at 0xFFFF. Read data returns to the datapath's MDR input together with a one-cycle ready (R) pulse. It sits between the datapath/ISDU and the board SRAM, switches and hex display.

Parameters:
WAIT_STATES, 2, SRAM cycles held in ACCESS before data is sampled; legal range 1..15.
IO_ADDR, 16'hFFFF, address decoded as the switch/hex I/O register.

Ports:
Clk  input  1  system clock; all state updates on its rising edge.
Reset  input  1  asynchronous, active-high reset.
MEM_EN  input  1  request strobe from control; held high until R.
WE  input  1  1 = write, 0 = read; sampled with MEM_EN in IDLE.
MAR  input  16  request address.
MDR_out  input  16  write data from the datapath.
MDR_in  output  16  read data to the datapath; valid while R = 1.
R  output  1  ready; single-cycle pulse when the access completes.
Switches  input  16  board switches, returned on I/O reads.
HEX_out  output  16  hex display register, written by I/O writes.
SRAM_ADDR  output  20  {4'b0, latched MAR}.
SRAM_DQ_wr  output  16  write data driven to SRAM.
SRAM_DQ_rd  input  16  read data from SRAM.
SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  output  1 each  active-low SRAM strobes.

Behaviour:
- Reset (asynchronous, immediate): state = IDLE, R = 0, MDR_in = 0, HEX_out = 0, SRAM_ADDR = 0, SRAM_DQ_wr = 0, and all SRAM strobes = 1. Reset mid-access aborts the access with no R pulse and no HEX_out update.
- States are IDLE, ACCESS, IO, DONE and RELEASE.
- IDLE: when MEM_EN = 1, latch MAR, WE and MDR_out. If MAR == IO_ADDR, go to IO; otherwise go to ACCESS with the wait counter = WAIT_STATES-1.
- ACCESS: SRAM_CE_N = 0. A read drives SRAM_OE_N = 0. A write drives SRAM_WE_N = 0 with SRAM_DQ_wr = latched data. The counter decrements each cycle. When it reaches 0, a read captures SRAM_DQ_rd into MDR_in, then the FSM goes to DONE.
- IO: one cycle. A read loads MDR_in with Switches sampled this cycle. A write loads HEX_out with the latched data. Then the FSM goes to DONE. SRAM strobes stay inactive.
- DONE: R = 1 for exactly one cycle. MDR_in holds its value until the next read completes; writes leave MDR_in unchanged. If MEM_EN = 1 go to RELEASE, otherwise go to IDLE.
- RELEASE: wait for MEM_EN = 0, then go to IDLE. This guarantees one access per request.
- Latency from the IDLE cycle that samples MEM_EN to R high: SRAM access = WAIT_STATES+1 cycles; I/O access = 2 cycles.
- MEM_EN dropped before R is a protocol violation. The access still completes, R still pulses, and DONE returns directly to IDLE.
- MAR, WE and MDR_out changes after acceptance are ignored, because the latched copies are used.
- Back-to-back requests: the minimum gap is one MEM_EN-low cycle, or zero if control drops MEM_EN in the R cycle.
- Address is passed through as-is, with no wrap-around or arithmetic. Only exact 16'hFFFF decodes as I/O; 16'hFFFE goes to SRAM.

Optional Feature:
ACCESS_STATS_EN
- Defined: adds output ports RD_COUNT[15:0] and WR_COUNT[15:0], both reset to 0.
  - Each counter increments in the DONE cycle for a completed read or write (SRAM and I/O alike).
  - Counters wrap from 16'hFFFF to 0.
  - An aborted access is not counted.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset, then read MAR = 16'h0010 with SRAM_DQ_rd = 16'hBEEF and WAIT_STATES = 2 -> SRAM_OE_N low for 2 cycles, R high in cycle 3, MDR_in = 16'hBEEF.
- Write MAR = 16'h0020, MDR_out = 16'h1234 -> SRAM_ADDR = 20'h00020, SRAM_WE_N low for 2 cycles with SRAM_DQ_wr = 16'h1234, R pulses once, MDR_in unchanged.
- I/O read at 16'hFFFF with Switches = 16'h00A5 -> R in cycle 2, MDR_in = 16'h00A5, SRAM_CE_N stays 1. I/O write of 16'h0C3D -> HEX_out = 16'h0C3D.
- Hold MEM_EN high for 10 cycles on one read -> exactly one R pulse, FSM parked in RELEASE until MEM_EN falls.
- Assert Reset during ACCESS of a write to 16'h0005 -> strobes go inactive immediately, no R pulse, HEX_out = 0. The next read completes normally.
- With ACCESS_STATS_EN: 3 reads and 2 writes -> RD_COUNT = 3, WR_COUNT = 2. Preset a counter at 16'hFFFF plus one access -> the counter wraps to 0.
